// File: rtl/alu_stream_if.sv
// alu_stream_if: byte-wide AXI-Stream link with a 12-bit status sideband
interface alu_stream_if;
  logic        tvalid;
  logic        tready;
  logic [7:0]  tdata;
  logic        tlast;
  logic [11:0] tuser;
  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/alu_stream.sv
// alu_stream: byte-serial ALU taking opcode/A/B command packets and returning framed results
module alu_stream #(
  parameter int OPERAND_BYTES = 2,
  parameter int LED_WIDTH = 16
) (
  input  logic                 aclk_i,
  input  logic                 rst_i,
  alu_stream_if.slave          s_axis,
  alu_stream_if.master         m_axis,
  output logic [LED_WIDTH-1:0] LED
);
  localparam int W = 8 * OPERAND_BYTES;
  localparam int CW = $clog2(2 * OPERAND_BYTES);
  localparam logic [CW-1:0] LAST_OP = CW'(OPERAND_BYTES - 1);
  localparam logic [CW-1:0] LAST_RES = CW'(2 * OPERAND_BYTES - 1);
  typedef enum logic [2:0] {OPCODE, RECV_A, RECV_B, DRAIN, EXEC, SEND} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] opcode;
  logic [W-1:0] a, b;
  logic [W:0] sum;
  logic [2*W-1:0] prod, r_calc, r_fin, res;
  logic [11:0] tuser;
  logic tready, tvalid, early, ferr, flag, bad, acc, hs, early_n, miss_n;
  assign acc = s_axis.tvalid && tready;
  assign hs = tvalid && m_axis.tready;
  assign sum = {1'b0, a} + {1'b0, b};
  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign bad = opcode > 8'h05;
  // tlast before the final B byte truncates the command; no tlast on it means trailing junk
  assign early_n = acc && s_axis.tlast && (state == OPCODE || state == RECV_A || (state == RECV_B && cnt != LAST_OP));
  assign miss_n = acc && !s_axis.tlast && state == RECV_B && cnt == LAST_OP;
  assign r_fin = (early || bad) ? '0 : r_calc;
  assign s_axis.tready = tready;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata = res[7:0];
  assign m_axis.tlast = tvalid && cnt == LAST_RES;
  assign m_axis.tuser = tuser;
  always_comb begin
    r_calc = '0;
    flag = 1'b0;
    case (opcode)
      8'h00: begin r_calc = {{(W-1){1'b0}}, sum}; flag = sum[W]; end
      8'h01: begin r_calc = {{W{1'b0}}, a - b}; flag = a < b; end
      8'h02: begin r_calc = prod; flag = |prod[2*W-1:W]; end
      8'h03: r_calc = {{W{1'b0}}, a & b};
      8'h04: r_calc = {{W{1'b0}}, a | b};
      8'h05: r_calc = {{W{1'b0}}, a ^ b};
      default: ;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      OPCODE: if (acc) state_n = s_axis.tlast ? EXEC : RECV_A;
      RECV_A: if (acc) state_n = s_axis.tlast ? EXEC : cnt == LAST_OP ? RECV_B : RECV_A;
      RECV_B: if (acc) state_n = s_axis.tlast ? EXEC : cnt == LAST_OP ? DRAIN : RECV_B;
      DRAIN:  if (acc && s_axis.tlast) state_n = EXEC;
      EXEC:   state_n = SEND;
      SEND:   if (hs && cnt == LAST_RES) state_n = OPCODE;
      default: state_n = OPCODE;
    endcase
  end
  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state <= OPCODE;
      tready <= 1'b0;
      tvalid <= 1'b0;
      cnt <= '0;
      opcode <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      tuser <= '0;
      early <= 1'b0;
      ferr <= 1'b0;
      LED <= '0;
    end else begin
      state <= state_n;
      tready <= state_n inside {OPCODE, RECV_A, RECV_B, DRAIN};
      if (acc && state == OPCODE) opcode <= s_axis.tdata;
      if (acc && state == RECV_A) a <= W'({s_axis.tdata, a} >> 8);
      if (acc && state == RECV_B) b <= W'({s_axis.tdata, b} >> 8);
      if (acc && state != DRAIN) cnt <= (state == OPCODE || cnt == LAST_OP) ? '0 : cnt + 1'b1;
      if (early_n) early <= 1'b1;
      if (early_n || miss_n) ferr <= 1'b1;
      if (state == EXEC) begin
        res <= r_fin;
        tuser <= {flag && !early, r_fin == '0, ferr, bad, opcode};
        tvalid <= 1'b1;
        cnt <= '0;
      end
      if (hs) begin
        res <= res >> 8;
        cnt <= cnt + 1'b1;
      end
      if (hs && cnt == LAST_RES) begin
        tvalid <= 1'b0;
        early <= 1'b0;
        ferr <= 1'b0;
        LED <= LED + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: scoreboard bench for alu_stream with OPERAND_BYTES=2
module tb_alu_stream;
  typedef struct { logic [31:0] r; logic [11:0] u; } exp_t;
  logic aclk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] led;
  int checks = 0, fails = 0, cyc = 0, beat_cyc = 0;
  exp_t sb[$];
  alu_stream_if s_if();
  alu_stream_if m_if();
  alu_stream #(.OPERAND_BYTES(2), .LED_WIDTH(16)) dut (
    .aclk_i(aclk), .rst_i(rst), .s_axis(s_if.slave), .m_axis(m_if.master), .LED(led)
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic fl;
    fl = 1'b0;
    e.r = 32'h0;
    if (op == 8'h00) begin e.r = 32'(a) + 32'(b); fl = e.r > 32'h0000_FFFF; end
    else if (op == 8'h01) begin e.r = 32'(16'(a - b)); fl = a < b; end
    else if (op == 8'h02) begin e.r = 32'(a) * 32'(b); fl = e.r > 32'h0000_FFFF; end
    else if (op == 8'h03) e.r = 32'(a & b);
    else if (op == 8'h04) e.r = 32'(a | b);
    else if (op == 8'h05) e.r = 32'(a ^ b);
    e.u = {fl, e.r == 32'h0, 1'b0, op > 8'h05, op};
    return e;
  endfunction

  task automatic put_beat(input logic [7:0] d, input logic l);
    int n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata = d;
    s_if.tlast = l;
    @(negedge aclk);
    while (!s_if.tready && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (s_if.tready !== 1'b1) begin fails++; $display("FAIL put_beat timeout byte %h got tready %b exp 1", d, s_if.tready); end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    beat_cyc = cyc - 1;
  endtask

  task automatic send_cmd(input logic [63:0] bytes, input int n, input int lpos);
    for (int i = 0; i < n; i++) put_beat(bytes[i*8 +: 8], i == lpos);
  endtask

  task automatic recv_pkt(output logic [31:0] r, output logic [3:0] l, output logic [11:0] u, output int vc);
    int idx = 0, n = 0;
    r = '0; l = '0; u = '0; vc = -1;
    m_if.tready = 1'b1;
    while (idx < 4 && n < 100) begin
      if (m_if.tvalid) begin
        if (vc < 0) vc = cyc;
        r[idx*8 +: 8] = m_if.tdata;
        l[idx] = m_if.tlast;
        u = m_if.tuser;
        idx++;
      end
      @(posedge aclk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser} !== 23'h0) begin
      fails++; $display("FAIL reset_outputs got %h exp 0", {s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser});
    end
    checks++;
    if (led !== 16'h0) begin fails++; $display("FAIL reset_led got %h exp 0", led); end
    rst = 1'b0;
    @(posedge aclk);
    #1;
    checks++;
    if (s_if.tready !== 1'b1) begin fails++; $display("FAIL idle_tready got %b exp 1", s_if.tready); end
  endtask

  task automatic test_arith;
    logic [63:0] cmd [3] = '{64'h00_01_FF_FF_00, 64'h00_10_12_34_02, 64'h00_02_00_01_01};
    exp_t ex [3] = '{'{32'h0001_0000, 12'h800}, '{32'h0001_2340, 12'h802}, '{32'h0000_FFFF, 12'h801}};
    logic [31:0] r; logic [3:0] l; logic [11:0] u; int vc; exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      send_cmd(cmd[i], 5, 4);
      recv_pkt(r, l, u, vc);
      e = sb.pop_front();
      checks++; if (r !== e.r) begin fails++; $display("FAIL arith%0d_data got %h exp %h", i, r, e.r); end
      checks++; if (u !== e.u) begin fails++; $display("FAIL arith%0d_tuser got %h exp %h", i, u, e.u); end
      checks++; if (l !== 4'b1000) begin fails++; $display("FAIL arith%0d_tlast got %b exp 1000", i, l); end
      checks++; if (vc - beat_cyc !== 2) begin fails++; $display("FAIL arith%0d_latency got %0d exp 2", i, vc - beat_cyc); end
    end
  endtask

  task automatic test_bad_opcode;
    logic [63:0] cmd [2] = '{64'h44_33_22_11_07, 64'h00_FF_00_0F_03};
    exp_t ex [2] = '{'{32'h0, 12'h507}, '{32'h0000_000F, 12'h003}};
    logic [31:0] r; logic [3:0] l; logic [11:0] u; int vc; exp_t e;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      send_cmd(cmd[i], 5, 4);
      recv_pkt(r, l, u, vc);
      e = sb.pop_front();
      checks++; if (r !== e.r) begin fails++; $display("FAIL op%0d_data got %h exp %h", i, r, e.r); end
      checks++; if (u !== e.u) begin fails++; $display("FAIL op%0d_tuser got %h exp %h", i, u, e.u); end
      checks++; if (l !== 4'b1000) begin fails++; $display("FAIL op%0d_tlast got %b exp 1000", i, l); end
    end
    checks++;
    if (led !== 16'd2) begin fails++; $display("FAIL led_count got %0d exp 2", led); end
  endtask

  task automatic test_framing;
    logic [63:0] cmd [2] = '{64'h00_05_00, 64'hBB_AA_00_02_00_01_04};
    int len [2] = '{3, 7};
    exp_t ex [2] = '{'{32'h0, 12'h600}, '{32'h0000_0003, 12'h204}};
    logic [31:0] r; logic [3:0] l; logic [11:0] u; int vc; exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      send_cmd(cmd[i], len[i], len[i] - 1);
      recv_pkt(r, l, u, vc);
      e = sb.pop_front();
      checks++; if (r !== e.r) begin fails++; $display("FAIL frame%0d_data got %h exp %h", i, r, e.r); end
      checks++; if (u !== e.u) begin fails++; $display("FAIL frame%0d_tuser got %h exp %h", i, u, e.u); end
      checks++; if (l !== 4'b1000) begin fails++; $display("FAIL frame%0d_tlast got %b exp 1000", i, l); end
      checks++; if (vc - beat_cyc !== 2) begin fails++; $display("FAIL frame%0d_latency got %0d exp 2", i, vc - beat_cyc); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] r; logic [3:0] l; logic [11:0] u; logic [20:0] held; logic stall;
    logic [7:0] op; logic [15:0] a, b; logic [15:0] led0; exp_t e;
    int idx, n;
    led0 = led;
    for (int p = 0; p < 8; p++) begin
      op = 8'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      sb.push_back(model(op, a, b));
      send_cmd({24'h0, b, a, op}, 5, 4);
      idx = 0; n = 0; stall = 1'b0; r = '0; l = '0; u = '0; held = '0;
      while (idx < 4 && n < 200) begin
        if (stall) begin
          checks++;
          if ({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser} !== {1'b1, held}) begin
            fails++; $display("FAIL bp%0d_hold got %h exp %h", p, {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}, {1'b1, held});
          end
        end
        if (m_if.tvalid) begin
          checks++;
          if (s_if.tready !== 1'b0) begin fails++; $display("FAIL bp%0d_slave_busy got %b exp 0", p, s_if.tready); end
        end
        m_if.tready = $urandom_range(0, 2) == 0;
        stall = m_if.tvalid && !m_if.tready;
        held = {m_if.tdata, m_if.tlast, m_if.tuser};
        if (m_if.tvalid && m_if.tready) begin
          r[idx*8 +: 8] = m_if.tdata;
          l[idx] = m_if.tlast;
          u = m_if.tuser;
          idx++;
        end
        @(posedge aclk);
        #1;
        n++;
      end
      m_if.tready = 1'b1;
      e = sb.pop_front();
      checks++; if (r !== e.r) begin fails++; $display("FAIL bp%0d_data op %h got %h exp %h", p, op, r, e.r); end
      checks++; if (u !== e.u) begin fails++; $display("FAIL bp%0d_tuser got %h exp %h", p, u, e.u); end
      checks++; if (l !== 4'b1000) begin fails++; $display("FAIL bp%0d_tlast got %b exp 1000", p, l); end
    end
    checks++;
    if (led !== 16'(led0 + 16'd8)) begin fails++; $display("FAIL bp_led got %0d exp %0d", led, 16'(led0 + 16'd8)); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; logic [3:0] l; logic [11:0] u; int vc, n; exp_t e;
    send_cmd(64'h00_01_FF_FF_00, 5, 4);
    m_if.tready = 1'b1;
    n = 0;
    while (!m_if.tvalid && n < 20) begin @(posedge aclk); #1; n++; end
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({m_if.tvalid, m_if.tdata} !== {1'b1, 8'h01}) begin fails++; $display("FAIL mid_byte2 got %h exp 101", {m_if.tvalid, m_if.tdata}); end
    rst = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if ({s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser} !== 23'h0) begin
      fails++; $display("FAIL mid_reset_outputs got %h exp 0", {s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser});
    end
    checks++;
    if (led !== 16'h0) begin fails++; $display("FAIL mid_reset_led got %h exp 0", led); end
    rst = 1'b0;
    sb.push_back('{32'h0000_00F0, 12'h005});
    send_cmd(64'h00_FF_00_0F_05, 5, 4);
    recv_pkt(r, l, u, vc);
    e = sb.pop_front();
    checks++; if (r !== e.r) begin fails++; $display("FAIL post_reset_data got %h exp %h", r, e.r); end
    checks++; if (u !== e.u) begin fails++; $display("FAIL post_reset_tuser got %h exp %h", u, e.u); end
    checks++; if (led !== 16'd1) begin fails++; $display("FAIL post_reset_led got %0d exp 1", led); end
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata = 8'h0;
    s_if.tlast = 1'b0;
    s_if.tuser = 12'h0;
    m_if.tready = 1'b0;
    test_reset;
    test_arith;
    test_bad_opcode;
    test_framing;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
